// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load / round-key read bus for aes_key_sched_ctrl.
// The zeroize strobe exists only when KEY_SCHED_ZEROIZE_EN is defined.
interface aes_key_sched_ctrl_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize;

  modport master (
    output key_valid, key_in, rk_idx, zeroize,
    input  key_ready, busy, keys_valid, done, rk_out
  );
  modport slave (
    input  key_valid, key_in, rk_idx, zeroize,
    output key_ready, busy, keys_valid, done, rk_out
  );
`else
  modport master (
    output key_valid, key_in, rk_idx,
    input  key_ready, busy, keys_valid, done, rk_out
  );
  modport slave (
    input  key_valid, key_in, rk_idx,
    output key_ready, busy, keys_valid, done, rk_out
  );
`endif
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock through a shared
// 4-sbox datapath, 11-entry key store. Optional KEY_SCHED_ZEROIZE_EN adds zeroize.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[{a, 3'b000} +: 8];
endmodule

module aes_key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned RD_REG     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_key_sched_ctrl_if.slave  bus
);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state_q, state_d;
  logic         ready_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic [127:0] work_q;
  logic         keys_valid_q;
  logic         done_q;
  logic [127:0] rk_mem [NUM_ROUNDS+1];

  logic         zeroize_c;
  logic         key_ready_c, busy_c, accept_c, last_c;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [127:0] next_key;
  logic [127:0] rd_c;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zeroize_c = bus.zeroize;
`else
  assign zeroize_c = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shared round datapath: RotWord of w3, then the only four sboxes.
  assign rot_w = {work_q[23:0], work_q[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[8*i +: 8]), .y(sub_w[8*i +: 8]));
  end
  assign t_w = sub_w ^ {rcon_q, 24'h0};
  assign next_key[127:96] = work_q[127:96] ^ t_w;
  assign next_key[95:64]  = work_q[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = work_q[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = work_q[31:0]   ^ next_key[63:32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    key_ready_c = 1'b0;
    busy_c      = 1'b0;
    accept_c    = 1'b0;
    last_c      = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready_c = ready_q && !zeroize_c;
        accept_c    = key_ready_c && bus.key_valid;
        if (accept_c) state_d = EXPAND;
      end
      EXPAND: begin
        busy_c = 1'b1;
        last_c = (round_q == LAST_RND);
        if (last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (zeroize_c) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      round_q      <= '0;
      rcon_q       <= 8'h01;
      work_q       <= '0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_mem[i] <= '0;
    end else begin
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      if (zeroize_c) begin
        round_q      <= '0;
        rcon_q       <= 8'h01;
        work_q       <= '0;
        keys_valid_q <= 1'b0;
        for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk_mem[i] <= '0;
      end else if (accept_c) begin
        rk_mem[0]    <= bus.key_in;
        work_q       <= bus.key_in;
        round_q      <= 4'd1;
        rcon_q       <= 8'h01;
        keys_valid_q <= 1'b0;
      end else if (busy_c) begin
        rk_mem[round_q] <= next_key;
        work_q          <= next_key;
        round_q         <= last_c ? '0 : round_q + 4'd1;
        rcon_q          <= last_c ? 8'h01 : xtime(rcon_q);
        if (last_c) begin
          keys_valid_q <= 1'b1;
          done_q       <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_c = '0;
    if (keys_valid_q && bus.rk_idx <= LAST_RND) rd_c = rk_mem[bus.rk_idx];
  end

  // Registered path is also gated by the live keys_valid so a new key
  // acceptance or zeroize hides stale data the very next cycle.
  if (RD_REG != 0) begin : g_rd_reg
    logic [127:0] rd_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_c;
    end
    assign bus.rk_out = keys_valid_q ? rd_q : '0;
  end else begin : g_rd_comb
    assign bus.rk_out = rd_c;
  end

  assign bus.key_ready  = key_ready_c;
  assign bus.busy       = busy_c;
  assign bus.keys_valid = keys_valid_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: FIPS-197 vectors, back-to-back keys,
// key held while busy, reset mid-expansion, optional zeroize.
module tb_aes_key_sched_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if bus();

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .RD_REG(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    string        name;
    logic [127:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic rd_req   = 1'b0;

  task automatic chk_key(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a read request sampled at an edge is answered after that edge.
  initial begin : monitor
    logic    s;
    rd_exp_t e;
    forever begin
      @(posedge clk);
      s = rd_req;
      @(negedge clk);
      if (s) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got read with empty queue expected queued entry");
        end else begin
          e = sb_q.pop_front();
          chk_key(e.name, bus.rk_out, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    bus.rk_idx = idx;
    rd_req     = 1'b1;
    sb_q.push_back(e);
    step();
  endtask

  task automatic rd_end();
    rd_req = 1'b0;
    step();
    chk_int("sb_drain", sb_q.size(), 0);
  endtask

  task automatic send_key(input logic [127:0] k, input bit hold, input logic [127:0] hold_key);
    int n;
    n = 0;
    bus.rk_idx = 4'd0;
    while (!bus.key_ready && n < 40) begin
      step();
      n++;
    end
    chk_bit("key_ready_wait", bus.key_ready, 1'b1);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    step();
    if (hold) bus.key_in = hold_key;
    else      bus.key_valid = 1'b0;
  endtask

  // Counts edges after acceptance until done; checks hiding mid-expansion.
  task automatic wait_done(input string tag);
    int c;
    bit got;
    c   = 0;
    got = 1'b0;
    while (!got && c < 30) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
      else begin
        if (c == 5) begin
          chk_bit({tag, "_mid_busy"}, bus.busy, 1'b1);
          chk_bit({tag, "_mid_keys_valid"}, bus.keys_valid, 1'b0);
          chk_key({tag, "_mid_rk_out"}, bus.rk_out, '0);
        end
        c++;
      end
    end
    chk_int({tag, "_done_latency"}, c, 10);
    if (got) begin
      @(negedge clk);
      chk_bit({tag, "_done_pulse"}, bus.done, 1'b0);
      chk_bit({tag, "_keys_valid"}, bus.keys_valid, 1'b1);
    end
    step();
  endtask

  initial begin : stim
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_idx    = '0;
`ifdef KEY_SCHED_ZEROIZE_EN
    bus.zeroize   = 1'b0;
`endif
    step();
    step();
    chk_bit("rst_key_ready", bus.key_ready, 1'b0);
    chk_bit("rst_busy", bus.busy, 1'b0);
    chk_bit("rst_keys_valid", bus.keys_valid, 1'b0);
    chk_bit("rst_done", bus.done, 1'b0);
    chk_key("rst_rk_out", bus.rk_out, '0);
    rst_n = 1'b1;
    #1;
    chk_bit("rel_key_ready_pre_edge", bus.key_ready, 1'b0);
    step();
    chk_bit("rel_key_ready", bus.key_ready, 1'b1);
    chk_bit("idle_busy", bus.busy, 1'b0);
    rd(4'd0, '0, "idle_rd0");
    rd(4'd5, '0, "idle_rd5");
    rd(4'd10, '0, "idle_rd10");
    rd(4'd15, '0, "idle_rd15");
    rd_end();

    // FIPS-197 key
    send_key(KEY_A, 1'b0, '0);
    wait_done("a");
    rd(4'd0, KEY_A, "a_rk0");
    rd(4'd1, A_RK1, "a_rk1");
    rd(4'd10, A_RK10, "a_rk10");
    rd(4'd11, '0, "a_rk11");
    rd(4'd15, '0, "a_rk15");
    rd_end();

    // Second key straight after
    send_key(KEY_B, 1'b0, '0);
    wait_done("b");
    rd(4'd0, KEY_B, "b_rk0");
    rd(4'd1, B_RK1, "b_rk1");
    rd(4'd10, B_RK10, "b_rk10");
    rd_end();

    // key_valid held with a different key while busy
    send_key(KEY_A, 1'b1, KEY_B);
    for (int i = 1; i <= 9; i++) begin
      chk_bit("hold_busy", bus.busy, 1'b1);
      chk_bit("hold_no_ready", bus.key_ready, 1'b0);
      step();
    end
    bus.key_in = KEY_A;
    step();
    chk_bit("hold_done", bus.done, 1'b1);
    chk_bit("hold_ready_after_done", bus.key_ready, 1'b1);
    step();
    chk_bit("hold_reaccept_busy", bus.busy, 1'b1);
    bus.key_valid = 1'b0;
    wait_done("hold");
    rd(4'd1, A_RK1, "hold_rk1");
    rd(4'd10, A_RK10, "hold_rk10");
    rd_end();

    // Reset in the middle of an expansion
    send_key(KEY_B, 1'b0, '0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk_bit("mid_rst_busy", bus.busy, 1'b0);
    chk_bit("mid_rst_keys_valid", bus.keys_valid, 1'b0);
    chk_bit("mid_rst_done", bus.done, 1'b0);
    chk_bit("mid_rst_key_ready", bus.key_ready, 1'b0);
    chk_key("mid_rst_rk_out", bus.rk_out, '0);
    step();
    step();
    rst_n = 1'b1;
    chk_bit("mid_rel_key_ready_pre_edge", bus.key_ready, 1'b0);
    step();
    chk_bit("mid_rel_key_ready", bus.key_ready, 1'b1);
    send_key(KEY_A, 1'b0, '0);
    wait_done("post_rst");
    rd(4'd0, KEY_A, "post_rst_rk0");
    rd(4'd10, A_RK10, "post_rst_rk10");
    rd_end();

`ifdef KEY_SCHED_ZEROIZE_EN
    bus.zeroize   = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_in    = KEY_B;
    #1;
    chk_bit("zero_key_ready", bus.key_ready, 1'b0);
    step();
    bus.zeroize   = 1'b0;
    bus.key_valid = 1'b0;
    chk_bit("zero_keys_valid", bus.keys_valid, 1'b0);
    chk_bit("zero_busy", bus.busy, 1'b0);
    for (int i = 0; i <= 10; i++) rd(4'(i), '0, "zero_rd");
    rd_end();
    chk_bit("zero_busy_after", bus.busy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
